// File: rtl/mips_wb_pkg.sv
`default_nettype none
// ============================================================================
// Package : mips_wb_pkg
// Brief   : Shared types and helpers for the MEM/WB pipeline stage: load
//           type encoding, write-back status encoding, extension helpers.
// Rev     : 1.0  initial release
// ============================================================================
package mips_wb_pkg;

    // Load flavours carried alongside a MEM-stage entry.
    typedef enum logic [2:0] {
        LT_WORD  = 3'd0,
        LT_HALF  = 3'd1,
        LT_HALFU = 3'd2,
        LT_BYTE  = 3'd3,
        LT_BYTEU = 3'd4
    } load_type_t;

    // Write-back stage status reported on wb_status.
    typedef enum logic [1:0] {
        WB_IDLE    = 2'd0,
        WB_ACTIVE  = 2'd1,
        WB_STALLED = 2'd2,
        WB_ERROR   = 2'd3
    } wb_state_t;

    // Widen a byte to 32 bits, replicating bit 7 when is_signed is set.
    function automatic logic [31:0] ext8(input logic [7:0] b, input logic is_signed);
        return {{24{is_signed & b[7]}}, b};
    endfunction

    // Widen a halfword to 32 bits, replicating bit 15 when is_signed is set.
    function automatic logic [31:0] ext16(input logic [15:0] h, input logic is_signed);
        return {{16{is_signed & h[15]}}, h};
    endfunction

endpackage : mips_wb_pkg
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module : load_align
// Brief  : Combinational big-endian load alignment. Picks the addressed
//          byte/halfword out of a memory word, extends it, and flags
//          accesses that are misaligned or use an unencoded load type.
// Rev    : 1.0  initial release
// ============================================================================
module load_align
    import mips_wb_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  loadtype,
    output logic [31:0] value,
    output logic        misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Big-endian byte select: offset 0 is the most significant byte.
    always_comb begin
        w_byte = word[31:24];
        case (offset)
            2'd0:    w_byte = word[31:24];
            2'd1:    w_byte = word[23:16];
            2'd2:    w_byte = word[15:8];
            default: w_byte = word[7:0];
        endcase
    end

    // Halfword at offset 0 is the upper half, offset 2 the lower half.
    assign w_half = offset[1] ? word[15:0] : word[31:16];

    // Extension and alignment check per load flavour; unknown codes trap.
    always_comb begin
        value      = 32'd0;
        misaligned = 1'b0;
        case (loadtype)
            LT_WORD: begin
                value      = word;
                misaligned = (offset != 2'd0);
            end
            LT_HALF: begin
                value      = ext16(w_half, 1'b1);
                misaligned = offset[0];
            end
            LT_HALFU: begin
                value      = ext16(w_half, 1'b0);
                misaligned = offset[0];
            end
            LT_BYTE: begin
                value      = ext8(w_byte, 1'b1);
            end
            LT_BYTEU: begin
                value      = ext8(w_byte, 1'b0);
            end
            default: begin
                value      = 32'd0;
                misaligned = 1'b1;
            end
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module : mem_wb_stage
// Brief  : MEM/WB pipeline register with load alignment, register-file write
//          port generation, retirement/misalignment counters and a status
//          state machine with a sticky error state.
// Rev    : 1.0  initial release
// ============================================================================
module mem_wb_stage
    import mips_wb_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_regwrite,
    input  logic             in_memtoreg,
    input  logic [4:0]       in_writereg,
    input  logic [31:0]      in_aluout,
    input  logic [31:0]      in_readdata,
    input  logic [2:0]       in_loadtype,
    output logic             we3,
    output logic [4:0]       wa3,
    output logic [31:0]      wd3,
    output logic [1:0]       wb_status,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] misalign_count
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // Stage register contents
    logic        r_valid;
    logic        r_regwrite;
    logic        r_memtoreg;
    logic [4:0]  r_writereg;
    logic [31:0] r_aluout;
    logic [31:0] r_readdata;
    logic [2:0]  r_loadtype;

    logic [CNT_W-1:0] r_retired_count;
    logic [CNT_W-1:0] r_misalign_count;

    wb_state_t r_state;
    wb_state_t w_state_next;

    logic [31:0] w_load_value;
    logic        w_align_mis;
    logic        w_mis;
    logic        w_leave;

    load_align u_load_align (
        .word       (r_readdata),
        .offset     (r_aluout[1:0]),
        .loadtype   (r_loadtype),
        .value      (w_load_value),
        .misaligned (w_align_mis)
    );

    // Misalignment only matters when the result actually comes from memory.
    assign w_mis   = r_memtoreg & w_align_mis;
    // The held entry leaves the stage on any unstalled edge.
    assign w_leave = r_valid & ~stall;

    assign we3 = w_leave & r_regwrite & (r_writereg != 5'd0) & ~w_mis;
    assign wa3 = r_writereg;
    assign wd3 = r_memtoreg ? w_load_value : r_aluout;

    assign retired_count  = r_retired_count;
    assign misalign_count = r_misalign_count;
    assign wb_status      = r_state;

    // Stage register: flush inserts a bubble (wins over stall), stall holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_writereg <= 5'd0;
            r_aluout   <= 32'd0;
            r_readdata <= 32'd0;
            r_loadtype <= 3'd0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_writereg <= 5'd0;
            r_aluout   <= 32'd0;
            r_readdata <= 32'd0;
            r_loadtype <= 3'd0;
        end else if (!stall) begin
            r_valid    <= in_valid;
            r_regwrite <= in_regwrite;
            r_memtoreg <= in_memtoreg;
            r_writereg <= in_writereg;
            r_aluout   <= in_aluout;
            r_readdata <= in_readdata;
            r_loadtype <= in_loadtype;
        end
    end

    // Saturating event counters, bumped as each valid entry leaves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_retired_count  <= '0;
            r_misalign_count <= '0;
        end else if (w_leave) begin
            if (r_retired_count != c_cnt_max) begin
                r_retired_count <= r_retired_count + c_cnt_one;
            end
            if (w_mis && (r_misalign_count != c_cnt_max)) begin
                r_misalign_count <= r_misalign_count + c_cnt_one;
            end
        end
    end

    // Status state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= WB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next status describes the entry held after the edge; error is sticky.
    always_comb begin
        w_state_next = r_state;
        if ((r_state == WB_ERROR) || (w_leave && w_mis)) begin
            w_state_next = WB_ERROR;
        end else if (flush) begin
            w_state_next = WB_IDLE;
        end else if (stall) begin
            w_state_next = r_valid ? WB_STALLED : WB_IDLE;
        end else begin
            w_state_next = in_valid ? WB_ACTIVE : WB_IDLE;
        end
    end

endmodule : mem_wb_stage
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_wb_stage
// Brief  : Self-checking bench for mem_wb_stage: directed vector table,
//          hand-written stall/flush/reset sequences, randomized traffic
//          against a behavioural reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_wb_stage;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             stall, flush, in_valid, in_regwrite, in_memtoreg;
    logic [4:0]       in_writereg;
    logic [31:0]      in_aluout, in_readdata;
    logic [2:0]       in_loadtype;
    logic             we3;
    logic [4:0]       wa3;
    logic [31:0]      wd3;
    logic [1:0]       wb_status;
    logic [CNT_W-1:0] retired_count, misalign_count;

    int tests = 0;
    int fails = 0;

    mem_wb_stage #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_regwrite    (in_regwrite),
        .in_memtoreg    (in_memtoreg),
        .in_writereg    (in_writereg),
        .in_aluout      (in_aluout),
        .in_readdata    (in_readdata),
        .in_loadtype    (in_loadtype),
        .we3            (we3),
        .wa3            (wa3),
        .wd3            (wd3),
        .wb_status      (wb_status),
        .retired_count  (retired_count),
        .misalign_count (misalign_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_valid, m_regwrite, m_memtoreg, m_err;
    logic [4:0]  m_wr;
    logic [31:0] m_alu, m_rd;
    int          m_lt, m_ret, m_mis, m_status;

    // Load result from first principles: shift the addressed bytes down.
    function automatic void ref_load(input logic [31:0] word, input int off, input int lt,
                                     output logic [31:0] val, output bit mis);
        logic [31:0] b, h;
        b   = (word >> (24 - 8*off)) & 32'hFF;
        h   = (off >= 2) ? (word & 32'hFFFF) : (word >> 16);
        val = 32'd0;
        mis = 1'b0;
        case (lt)
            0: begin val = word; mis = (off != 0); end
            1: begin val = (h >= 32'h8000) ? h + 32'hFFFF_0000 : h; mis = (off % 2 == 1); end
            2: begin val = h; mis = (off % 2 == 1); end
            3: val = (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
            4: val = b;
            default: mis = 1'b1;
        endcase
    endfunction

    function automatic bit model_mis();
        logic [31:0] v;
        bit          m;
        ref_load(m_rd, int'(m_alu[1:0]), m_lt, v, m);
        return m_memtoreg && m;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_regwrite = 0; m_memtoreg = 0; m_err = 0;
        m_wr = 0; m_alu = 0; m_rd = 0; m_lt = 0;
        m_ret = 0; m_mis = 0; m_status = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic f, input logic v, input logic rw,
                         input logic mr, input logic [4:0] wr, input logic [31:0] alu,
                         input logic [31:0] rd, input logic [2:0] lt);
        stall = s; flush = f; in_valid = v; in_regwrite = rw; in_memtoreg = mr;
        in_writereg = wr; in_aluout = alu; in_readdata = rd; in_loadtype = lt;
    endtask

    task automatic drive_bubble();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 3'd0);
    endtask

    // Compare the write port against the model's held entry and current stall.
    task automatic check_comb();
        logic [31:0] v;
        bit          m, misx, exp_we;
        ref_load(m_rd, int'(m_alu[1:0]), m_lt, v, m);
        misx   = m_memtoreg && m;
        exp_we = m_valid && m_regwrite && (m_wr != 0) && !misx && !stall;
        chk("we3", {31'd0, we3}, {31'd0, exp_we});
        if (m_valid) begin
            chk("wa3", {27'd0, wa3}, {27'd0, m_wr});
            if (!misx) chk("wd3", wd3, m_memtoreg ? v : m_alu);
        end
    endtask

    // Clock edge: advance the model, then compare registered outputs.
    task automatic tick();
        bit leave, misx, prev_valid;
        @(posedge clk);
        leave      = m_valid && !stall;
        misx       = model_mis();
        prev_valid = m_valid;
        if (leave) begin
            if (m_ret < CNT_MAX) m_ret++;
            if (misx) begin
                if (m_mis < CNT_MAX) m_mis++;
                m_err = 1;
            end
        end
        if (flush) begin
            m_valid = 0; m_regwrite = 0; m_memtoreg = 0;
            m_wr = 0; m_alu = 0; m_rd = 0; m_lt = 0;
        end else if (!stall) begin
            m_valid = in_valid; m_regwrite = in_regwrite; m_memtoreg = in_memtoreg;
            m_wr = in_writereg; m_alu = in_aluout; m_rd = in_readdata; m_lt = int'(in_loadtype);
        end
        if (m_err)      m_status = 3;
        else if (flush) m_status = 0;
        else if (stall) m_status = prev_valid ? 2 : 0;
        else            m_status = in_valid ? 1 : 0;
        #1;
        chk("retired_count", {28'd0, retired_count}, m_ret);
        chk("misalign_count", {28'd0, misalign_count}, m_mis);
        chk("wb_status", {30'd0, wb_status}, m_status);
    endtask

    task automatic cycle();
        #3;
        check_comb();
        tick();
    endtask

    // Reset pulsed between edges; outputs must clear without a clock.
    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        chk({tag, "_we3"}, {31'd0, we3}, 32'd0);
        chk({tag, "_wa3"}, {27'd0, wa3}, 32'd0);
        chk({tag, "_wd3"}, wd3, 32'd0);
        chk({tag, "_retired"}, {28'd0, retired_count}, 32'd0);
        chk({tag, "_misalign"}, {28'd0, misalign_count}, 32'd0);
        chk({tag, "_status"}, {30'd0, wb_status}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        memtoreg;
        logic        regwrite;
        logic [4:0]  wr;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [2:0]  lt;
        logic        exp_we3;
        logic        chk_wd;
        logic [31:0] exp_wd3;
        logic        exp_mis;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int exp_mis_cnt;

        tbl[0]  = '{1'b0, 1'b1, 5'd8,  32'h0000_0010, 32'h0,          3'd0, 1'b1, 1'b1, 32'h0000_0010, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 5'd3,  32'h0000_1001, 32'h1285_3456, 3'd3, 1'b1, 1'b1, 32'hFFFF_FF85, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 5'd3,  32'h0000_1001, 32'h1285_3456, 3'd4, 1'b1, 1'b1, 32'h0000_0085, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 5'd4,  32'h0000_2002, 32'h0000_F00D, 3'd1, 1'b1, 1'b1, 32'hFFFF_F00D, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 5'd5,  32'h0000_2000, 32'hF00D_1234, 3'd2, 1'b1, 1'b1, 32'h0000_F00D, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 5'd6,  32'h0000_3000, 32'hDEAD_BEEF, 3'd0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 5'd7,  32'h0000_3004, 32'h7F00_0000, 3'd3, 1'b1, 1'b1, 32'h0000_007F, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 5'd9,  32'h0000_3007, 32'h0000_00C3, 3'd3, 1'b1, 1'b1, 32'hFFFF_FFC3, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 5'd10, 32'h0000_300A, 32'h0000_AB00, 3'd4, 1'b1, 1'b1, 32'h0000_00AB, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 5'd0,  32'h0000_0055, 32'h0,          3'd0, 1'b0, 1'b1, 32'h0000_0055, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 5'd11, 32'h0000_4002, 32'h1111_2222, 3'd0, 1'b0, 1'b0, 32'h0,          1'b1};
        tbl[11] = '{1'b1, 1'b1, 5'd12, 32'h0000_2003, 32'h0000_F00D, 3'd1, 1'b0, 1'b0, 32'h0,          1'b1};
        tbl[12] = '{1'b1, 1'b1, 5'd13, 32'h0000_5000, 32'h3333_4444, 3'd5, 1'b0, 1'b0, 32'h0,          1'b1};
        tbl[13] = '{1'b0, 1'b1, 5'd14, 32'h0000_6001, 32'h5555_6666, 3'd0, 1'b1, 1'b1, 32'h0000_6001, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 5'd15, 32'h0000_7000, 32'h0,          3'd0, 1'b0, 1'b1, 32'h0000_7000, 1'b0};

        // ---- reset state ----
        reset_n = 1'b0;
        drive_bubble();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_we3", {31'd0, we3}, 32'd0);
        chk("rst_wa3", {27'd0, wa3}, 32'd0);
        chk("rst_wd3", wd3, 32'd0);
        chk("rst_retired", {28'd0, retired_count}, 32'd0);
        chk("rst_misalign", {28'd0, misalign_count}, 32'd0);
        chk("rst_status", {30'd0, wb_status}, 32'd0);
        reset_n = 1'b1;

        // ---- directed vector table ----
        exp_mis_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b0, 1'b1, tbl[i].regwrite, tbl[i].memtoreg, tbl[i].wr,
                  tbl[i].alu, tbl[i].rd, tbl[i].lt);
            cycle();
            drive_bubble();
            #3;
            check_comb();
            chk($sformatf("tbl%0d_we3", i), {31'd0, we3}, {31'd0, tbl[i].exp_we3});
            chk($sformatf("tbl%0d_wa3", i), {27'd0, wa3}, {27'd0, tbl[i].wr});
            if (tbl[i].chk_wd) chk($sformatf("tbl%0d_wd3", i), wd3, tbl[i].exp_wd3);
            if (tbl[i].exp_mis) exp_mis_cnt++;
            tick();
            chk($sformatf("tbl%0d_retired", i), {28'd0, retired_count}, i + 1);
            chk($sformatf("tbl%0d_misalign", i), {28'd0, misalign_count}, exp_mis_cnt);
            if (exp_mis_cnt > 0) chk($sformatf("tbl%0d_error", i), {30'd0, wb_status}, 32'd3);
        end
        // Saturation: retired_count is already all-ones; one more retire holds it.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 32'h99, 32'h0, 3'd0);
        cycle();
        drive_bubble();
        #3;
        chk("err_still_writes", {31'd0, we3}, 32'd1);
        check_comb();
        tick();
        chk("sat_retired", {28'd0, retired_count}, 32'd15);

        // ---- stall held three cycles, then release; stall+flush bubble ----
        async_reset("rst_a");
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_1234, 32'h0, 3'd0);
        cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd17, 32'h0000_0BAD, 32'h0, 3'd0);
            #3;
            check_comb();
            chk("stall_we3", {31'd0, we3}, 32'd0);
            chk("stall_wa3", {27'd0, wa3}, 32'd9);
            tick();
            chk("stall_status", {30'd0, wb_status}, 32'd2);
            chk("stall_retired", {28'd0, retired_count}, 32'd0);
        end
        drive_bubble();
        #3;
        check_comb();
        chk("release_we3", {31'd0, we3}, 32'd1);
        chk("release_wd3", wd3, 32'h0000_1234);
        tick();
        chk("release_retired", {28'd0, retired_count}, 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd10, 32'h0000_00AA, 32'h0, 3'd0);
        cycle();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd11, 32'h0000_00BB, 32'h0, 3'd0);
        cycle();
        chk("flush_status", {30'd0, wb_status}, 32'd0);
        drive_bubble();
        #3;
        check_comb();
        chk("flush_we3", {31'd0, we3}, 32'd0);
        tick();
        chk("flush_retired", {28'd0, retired_count}, 32'd1);

        // ---- reset asserted mid-stall, off the clock edge ----
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd12, 32'h0000_0CCC, 32'h0, 3'd0);
        cycle();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd13, 32'h0000_0DDD, 32'h0, 3'd0);
        cycle();
        async_reset("rst_b");
        drive_bubble();
        cycle();
        chk("rst_b_after", {28'd0, retired_count}, 32'd0);

        // ---- randomized traffic against the reference model ----
        for (int n = 0; n < 700; n++) begin
            if (n % 80 == 79) begin
                drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'($urandom), $urandom, $urandom, 3'd0);
                async_reset("rnd_rst");
            end else begin
                drive(($urandom % 4) == 0,
                      ($urandom % 10) == 0,
                      ($urandom % 4) != 0,
                      ($urandom % 5) != 0,
                      1'($urandom),
                      5'($urandom),
                      $urandom,
                      $urandom,
                      (($urandom % 8) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)));
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_mem_wb_stage
`default_nettype wire

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 32, giving counter width.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall  in  1  hold stage contents.
REQ-005 SHALL have port flush  in  1  replace captured entry with bubble.
REQ-006 SHALL have port in_valid  in  1  MEM-stage entry valid.
REQ-007 SHALL have port in_regwrite  in  1  entry writes a register.
REQ-008 SHALL have port in_memtoreg  in  1  result source: 1 = load data, 0 = ALU.
REQ-009 SHALL have port in_writereg  in  5  destination register number.
REQ-010 SHALL have port in_aluout  in  32  ALU result, also byte address for loads.
REQ-011 SHALL have port in_readdata  in  32  raw big-endian memory word.
REQ-012 SHALL have port in_loadtype  in  3  load_type_t.
REQ-013 SHALL have ports we3 / wa3 / wd3  out  1/5/32  regfile write port.
REQ-014 SHALL have port wb_status  out  2  wb_state_t.
REQ-015 SHALL have ports retired_count / misalign_count  out  CNT_W/CNT_W  event counters.

Function
REQ-016 Stage register SHALL capture every in_* signal on each clk edge when stall=0 and flush=0.
REQ-017 When flush=1, captured valid SHALL become 0 on the next edge; flush SHALL take priority over stall.
REQ-018 When stall=1 and flush=0, all stage contents SHALL hold.
REQ-019 Latency SHALL be one cycle: input at edge N appears on we3/wa3/wd3 after edge N.
REQ-020 we3 SHALL be 1 only when: valid, regwrite, wa3 != 0, no misalignment, and stall=0.
REQ-021 wa3 SHALL be the registered writereg.
REQ-022 wd3 SHALL be the registered aluout when memtoreg=0, else the aligned load value.
REQ-023 Byte offset SHALL be aluout[1:0]; byte offset 0 SHALL select bits 31:24 (big-endian).
REQ-024 Load alignment: LT_WORD = whole word; LT_HALF/LT_HALFU = halfword at offset 0 or 2, sign/zero extended; LT_BYTE/LT_BYTEU = selected byte, sign/zero extended.
REQ-025 Misaligned access SHALL be: LT_WORD with offset != 0, or halfword with offset[0]=1; it applies only when memtoreg=1.
REQ-026 Unencoded loadtype values SHALL be treated as misaligned.
REQ-027 retired_count SHALL increment once per valid entry leaving the stage (valid and stall=0), including writes to $0.
REQ-028 misalign_count SHALL increment once per misaligned valid entry leaving the stage.
REQ-029 Counters SHALL saturate at all-ones.
REQ-030 A stalled entry SHALL be counted once, on the cycle it leaves the stage.
REQ-031 wb_status state machine SHALL have these transitions:
- WB_IDLE: held entry invalid.
- WB_ACTIVE: valid entry, stall=0.
- WB_STALLED: stall=1 with valid entry.
- WB_ERROR: sticky after first misalignment; exits only via reset.
REQ-032 WB_ERROR SHALL NOT block further retirement.

Reset
REQ-033 reset_n=0 SHALL immediately clear: valid, regwrite, memtoreg, writereg, aluout, readdata, loadtype, both counters, and wb_status=WB_IDLE.
REQ-034 Therefore during reset we3=0, wa3=0, wd3=0.
REQ-035 Reset asserted mid-stall SHALL discard the held entry, leaving nothing counted.

Structure
REQ-036 Package mips_wb_pkg SHALL hold:
- load_type_t: LT_WORD=0, LT_HALF=1, LT_HALFU=2, LT_BYTE=3, LT_BYTEU=4.
- wb_state_t: WB_IDLE=0, WB_ACTIVE=1, WB_STALLED=2, WB_ERROR=3.
REQ-037 Alignment and extension SHALL be a combinational sub-module load_align, with inputs word, offset, loadtype and outputs value, misaligned.

Verification
REQ-038 Scenario: ALU write, writereg=8, aluout=0x0000_0010, memtoreg=0 -> next cycle we3=1, wa3=8, wd3=0x0000_0010, retired_count=1.
REQ-039 Scenario: LT_BYTE, readdata=0x12_85_34_56, aluout=...01 -> wd3=0xFFFF_FF85; LT_BYTEU -> wd3=0x0000_0085.
REQ-040 Scenario: LT_HALF, aluout=...02, readdata=0x0000_F00D -> wd3=0xFFFF_F00D; with aluout=...03 -> we3=0, misalign_count=1, wb_status=WB_ERROR.
REQ-041 Scenario: writereg=0, regwrite=1 -> we3=0, retired_count increments.
REQ-042 Scenario: stall held 3 cycles with valid entry -> we3=0, wb_status=WB_STALLED, counters unchanged; stall+flush together -> bubble, we3=0.
REQ-043 Scenario: reset_n pulsed low mid-stall, off clock edge -> outputs zero immediately, counters 0, wb_status=WB_IDLE.
